dm_access_ctrl: RTL and testbench

Sequencer for the data-memory stage of the 16-bit pipeline. It takes the memory request held in the EX/DM pipeline latch, drives one read or write transaction into a multi-cycle data memory with a stall/done handshake, and stalls the pipeline until the transaction completes. It returns read data and flags errors. It also drains any outstanding access before acknowledging a halt.

---
 rtl/dm_ctrl_pkg.sv | 14 +
 rtl/dm_wait_timer.sv | 28 ++
 rtl/dm_access_ctrl.sv | 130 +++++++++++++
 tb/tb_dm_access_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared types and constants for the data-memory access sequencer.
package dm_ctrl_pkg;

   localparam int DATA_W      = 16;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } dm_state_e;

endpackage

// File: rtl/dm_wait_timer.sv
// WAIT-cycle counter with clear/enable; flags the last permitted WAIT cycle.
module dm_wait_timer
   import dm_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [7:0] count;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= 8'd0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   // Count starts at 0 in the first WAIT cycle, so this marks WAIT cycle number TIMEOUT_CYC.
   assign expired = (count == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory stage sequencer: one read/write per request, stall/done handshake, halt drain.
// Optional build macro ALIGN_CHECK_EN faults odd-address requests without a memory strobe.
module dm_access_ctrl
   import dm_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] EXDM_ALU,
   input  logic [DATA_W-1:0] EXDM_RTData,
   input  logic              EXDM_MemRead,
   input  logic              EXDM_MemWrt,
   input  logic              EXDM_HaltSig,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_en,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_stall,
   input  logic              mem_done,
   output logic              dm_stall,
   output logic [DATA_W-1:0] DM_rdata,
   output logic              DM_valid,
   output logic              DM_err,
   output logic              halt_done
);

   dm_state_e state, next_state;
   logic      req_any, req_one, req_bad, misalign;
   logic      fault, tmr_clr, tmr_en, tmr_expired;
   logic      halt_pend;

   dm_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   assign req_any = EXDM_MemRead | EXDM_MemWrt;
   assign req_one = EXDM_MemRead ^ EXDM_MemWrt;
   assign req_bad = EXDM_MemRead & EXDM_MemWrt;

`ifdef ALIGN_CHECK_EN
   assign misalign = req_one & EXDM_ALU[0];
`else
   assign misalign = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      fault      = 1'b0;
      tmr_clr    = 1'b0;
      tmr_en     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_bad || misalign) begin
               next_state = ST_DONE;
               fault      = 1'b1;
            end else if (req_one) begin
               next_state = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!mem_stall) begin
               next_state = ST_WAIT;
               tmr_clr    = 1'b1;
            end
         end
         ST_WAIT: begin
            tmr_en = 1'b1;
            // A done arriving in the final WAIT cycle still completes the access.
            if (mem_done) begin
               next_state = ST_DONE;
            end else if (tmr_expired) begin
               next_state = ST_DONE;
               fault      = 1'b1;
            end
         end
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   assign dm_stall = ((state == ST_IDLE) && req_any) || (state == ST_ISSUE) || (state == ST_WAIT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         DM_rdata  <= '0;
         DM_valid  <= 1'b0;
         DM_err    <= 1'b0;
         halt_done <= 1'b0;
         halt_pend <= 1'b0;
      end else begin
         state    <= next_state;
         mem_en   <= (next_state == ST_ISSUE);
         DM_valid <= (next_state == ST_DONE) && !fault;
         DM_err   <= (next_state == ST_DONE) && fault;

         if ((state == ST_IDLE) && (next_state == ST_ISSUE)) begin
            mem_addr  <= EXDM_ALU;
            mem_wdata <= EXDM_RTData;
            mem_wr    <= EXDM_MemWrt;
         end

         if ((state == ST_WAIT) && mem_done && !mem_wr) begin
            DM_rdata <= mem_rdata;
         end

         // A halt seen alongside a request is deferred until that access leaves DONE.
         if ((state == ST_IDLE) && EXDM_HaltSig) begin
            if (req_any) halt_pend <= 1'b1;
            else         halt_done <= 1'b1;
         end
         if ((state == ST_DONE) && halt_pend) begin
            halt_done <= 1'b1;
            halt_pend <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed self-checking bench for dm_access_ctrl, built with TIMEOUT_CYC = 4.
module tb_dm_access_ctrl;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] EXDM_ALU = '0, EXDM_RTData = '0, mem_rdata = '0;
   logic        EXDM_MemRead = 1'b0, EXDM_MemWrt = 1'b0, EXDM_HaltSig = 1'b0;
   logic        mem_stall = 1'b0, mem_done = 1'b0;
   logic [15:0] mem_addr, mem_wdata, DM_rdata;
   logic        mem_en, mem_wr, dm_stall, DM_valid, DM_err, halt_done;

   int checks = 0;
   int passed = 0;

   dm_access_ctrl #(.TIMEOUT_CYC(TMO)) dut (
      .clk          (clk),
      .rst          (rst),
      .EXDM_ALU     (EXDM_ALU),
      .EXDM_RTData  (EXDM_RTData),
      .EXDM_MemRead (EXDM_MemRead),
      .EXDM_MemWrt  (EXDM_MemWrt),
      .EXDM_HaltSig (EXDM_HaltSig),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_en       (mem_en),
      .mem_wr       (mem_wr),
      .mem_rdata    (mem_rdata),
      .mem_stall    (mem_stall),
      .mem_done     (mem_done),
      .dm_stall     (dm_stall),
      .DM_rdata     (DM_rdata),
      .DM_valid     (DM_valid),
      .DM_err       (DM_err),
      .halt_done    (halt_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      EXDM_MemRead = 1'b0; EXDM_MemWrt = 1'b0; EXDM_HaltSig = 1'b0;
      mem_stall = 1'b0; mem_done = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++;
      if ({mem_en, mem_wr, DM_valid, DM_err, halt_done, dm_stall} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000", {mem_en, mem_wr, DM_valid, DM_err, halt_done, dm_stall});
      else passed++;
      checks++;
      if ({mem_addr, mem_wdata, DM_rdata} !== 48'h0)
         $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_wdata, DM_rdata);
      else passed++;
   endtask

   task automatic test_load();
      int stall_cyc = 0, en_cyc = 0;
      EXDM_MemRead = 1'b1; EXDM_ALU = 16'h0040;
      #1;
      stall_cyc += int'(dm_stall); en_cyc += int'(mem_en);           // IDLE
      tick();
      checks++;
      if ({mem_en, mem_wr, mem_addr} !== {1'b1, 1'b0, 16'h0040})
         $display("FAIL load_issue: got en=%b wr=%b addr=%h want en=1 wr=0 addr=0040", mem_en, mem_wr, mem_addr);
      else passed++;
      stall_cyc += int'(dm_stall); en_cyc += int'(mem_en);           // ISSUE
      tick();
      mem_done = 1'b1; mem_rdata = 16'hBEEF;
      #1;
      stall_cyc += int'(dm_stall); en_cyc += int'(mem_en);           // WAIT
      tick();
      mem_done = 1'b0; mem_rdata = 16'h0000;
      stall_cyc += int'(dm_stall); en_cyc += int'(mem_en);           // DONE
      checks++;
      if ({DM_valid, DM_err, DM_rdata} !== {1'b1, 1'b0, 16'hBEEF})
         $display("FAIL load_done: got valid=%b err=%b rdata=%h want 1 0 beef", DM_valid, DM_err, DM_rdata);
      else passed++;
      checks++;
      if (stall_cyc !== 3 || en_cyc !== 1)
         $display("FAIL load_counts: got stall=%0d en=%0d want stall=3 en=1", stall_cyc, en_cyc);
      else passed++;
      EXDM_MemRead = 1'b0;
      tick();
      checks++;
      if ({DM_valid, dm_stall} !== 2'b00)
         $display("FAIL load_retire: got valid=%b stall=%b want 00", DM_valid, dm_stall);
      else passed++;
   endtask

   task automatic test_store_stall();
      int en_cyc = 0, bad = 0;
      EXDM_MemWrt = 1'b1; EXDM_ALU = 16'h0010; EXDM_RTData = 16'h1234; mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 2) mem_stall = 1'b0;
         en_cyc += int'(mem_en);
         if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 16'h0010, 16'h1234}) bad++;
      end
      tick();
      en_cyc += int'(mem_en);
      checks++;
      if (en_cyc !== 3 || bad !== 0)
         $display("FAIL store_issue: got en_cycles=%0d unstable=%0d want 3 0", en_cyc, bad);
      else passed++;
      tick();
      checks++;
      if (DM_valid !== 1'b0)
         $display("FAIL store_early_valid: got %b want 0", DM_valid);
      else passed++;
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      checks++;
      if ({DM_valid, DM_err, DM_rdata} !== {1'b1, 1'b0, 16'hBEEF})
         $display("FAIL store_done: got valid=%b err=%b rdata=%h want 1 0 beef", DM_valid, DM_err, DM_rdata);
      else passed++;
      EXDM_MemWrt = 1'b0;
      tick();
   endtask

   task automatic test_timeout();
      int n = 0;
      int valid_seen = 0;
      EXDM_MemRead = 1'b1; EXDM_ALU = 16'h0022;
      tick(); tick();                                              // now in WAIT cycle 1
      while (!DM_err && n < 20) begin
         valid_seen += int'(DM_valid);
         tick();
         n++;
      end
      checks++;
      if (n !== TMO || DM_err !== 1'b1 || DM_valid !== 1'b0 || valid_seen !== 0)
         $display("FAIL timeout: got wait_cycles=%0d err=%b valid=%b want %0d 1 0", n, DM_err, DM_valid, TMO);
      else passed++;
      checks++;
      if ({DM_rdata, dm_stall} !== {16'hBEEF, 1'b0})
         $display("FAIL timeout_rdata: got rdata=%h stall=%b want beef 0", DM_rdata, dm_stall);
      else passed++;
      EXDM_MemRead = 1'b0; mem_done = 1'b1; mem_rdata = 16'h7777;
      tick();
      mem_done = 1'b0;
      tick();
      checks++;
      if ({DM_valid, DM_err, DM_rdata} !== {1'b0, 1'b0, 16'hBEEF})
         $display("FAIL late_done: got valid=%b err=%b rdata=%h want 0 0 beef", DM_valid, DM_err, DM_rdata);
      else passed++;
   endtask

   task automatic test_conflict();
      EXDM_MemRead = 1'b1; EXDM_MemWrt = 1'b1; EXDM_ALU = 16'h0050;
      #1;
      checks++;
      if (dm_stall !== 1'b1)
         $display("FAIL conflict_stall: got %b want 1", dm_stall);
      else passed++;
      tick();
      checks++;
      if ({DM_err, DM_valid, mem_en, dm_stall} !== 4'b1000)
         $display("FAIL conflict: got err=%b valid=%b en=%b stall=%b want 1 0 0 0", DM_err, DM_valid, mem_en, dm_stall);
      else passed++;
      clear_inputs();
      tick();
      EXDM_MemRead = 1'b1; EXDM_ALU = 16'h0003;
      tick();
`ifdef ALIGN_CHECK_EN
      checks++;
      if ({DM_err, DM_valid, mem_en, DM_rdata} !== {3'b100, 16'hBEEF})
         $display("FAIL misalign: got err=%b valid=%b en=%b rdata=%h want 1 0 0 beef", DM_err, DM_valid, mem_en, DM_rdata);
      else passed++;
      clear_inputs();
      tick();
`else
      checks++;
      if ({mem_en, mem_addr} !== {1'b1, 16'h0003})
         $display("FAIL odd_addr: got en=%b addr=%h want 1 0003", mem_en, mem_addr);
      else passed++;
      tick();
      mem_done = 1'b1; mem_rdata = 16'h5A5A;
      tick();
      clear_inputs();
      checks++;
      if ({DM_valid, DM_rdata} !== {1'b1, 16'h5A5A})
         $display("FAIL odd_addr_done: got valid=%b rdata=%h want 1 5a5a", DM_valid, DM_rdata);
      else passed++;
      tick();
`endif
   endtask

   task automatic test_halt();
      EXDM_MemRead = 1'b1; EXDM_HaltSig = 1'b1; EXDM_ALU = 16'h0080;
      tick(); tick();                                              // ISSUE, then WAIT
      mem_done = 1'b1; mem_rdata = 16'h1357;
      checks++;
      if (halt_done !== 1'b0)
         $display("FAIL halt_early: got %b want 0", halt_done);
      else passed++;
      tick();
      mem_done = 1'b0;
      checks++;
      if ({DM_valid, halt_done} !== 2'b10)
         $display("FAIL halt_done_state: got valid=%b halt=%b want 1 0", DM_valid, halt_done);
      else passed++;
      clear_inputs();
      tick();
      checks++;
      if (halt_done !== 1'b1)
         $display("FAIL halt_after_valid: got %b want 1", halt_done);
      else passed++;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (halt_done !== 1'b0)
         $display("FAIL halt_clear: got %b want 0", halt_done);
      else passed++;
      EXDM_HaltSig = 1'b1;
      #1;
      checks++;
      if (dm_stall !== 1'b0)
         $display("FAIL halt_alone_stall: got %b want 0", dm_stall);
      else passed++;
      tick();
      checks++;
      if (halt_done !== 1'b1)
         $display("FAIL halt_alone: got %b want 1", halt_done);
      else passed++;
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      EXDM_MemRead = 1'b1; EXDM_ALU = 16'h0044; mem_rdata = 16'hFFFF;
      tick(); tick();                                              // in WAIT
      rst = 1'b1; EXDM_MemRead = 1'b0;
      tick();
      rst = 1'b0;
      checks++;
      if ({mem_en, mem_wr, DM_valid, DM_err, halt_done, dm_stall, mem_addr, DM_rdata} !== 38'h0)
         $display("FAIL reset_mid_wait: got en=%b valid=%b err=%b addr=%h rdata=%h stall=%b want all 0",
                  mem_en, DM_valid, DM_err, mem_addr, DM_rdata, dm_stall);
      else passed++;
      mem_done = 1'b1;
      tick();
      mem_done = 1'b0;
      tick();
      checks++;
      if ({DM_valid, DM_err, mem_en, DM_rdata} !== {3'b000, 16'h0000})
         $display("FAIL reset_late_done: got valid=%b err=%b en=%b rdata=%h want 0 0 0 0000",
                  DM_valid, DM_err, mem_en, DM_rdata);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_load();
      test_store_stall();
      test_timeout();
      test_conflict();
      test_halt();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
